// File: rtl/pht_update_ctrl.sv
// pht_update_ctrl: write-side controller for the pattern history table.
// Execute-stage updates are queued and applied one at a time as a
// read-modify-write of the 2-bit counter. The read uses the port shared
// with fetch, and fetch always has priority on that port. After reset,
// and on every predictor flush, the controller first sweeps the whole
// table to INIT_COUNTER.
module pht_update_ctrl #(
    parameter int         PHT_INDEX_WIDTH = 10,
    parameter int         QUEUE_DEPTH     = 4,
    parameter logic [1:0] INIT_COUNTER    = 2'b01
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [PHT_INDEX_WIDTH-1:0] upd_index,
    input  logic                       upd_taken,
    input  logic                       flush_req,
    input  logic                       fetch_rd_active,
    output logic                       pht_rd_en,
    output logic [PHT_INDEX_WIDTH-1:0] pht_rd_index,
    input  logic [1:0]                 pht_rd_data,
    output logic                       pht_wr_en,
    output logic [PHT_INDEX_WIDTH-1:0] pht_wr_index,
    output logic [1:0]                 pht_wr_data,
    output logic                       init_busy
);

    localparam int QPTR_W = $clog2(QUEUE_DEPTH);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PHT_INDEX_WIDTH-1:0] LAST_INDEX = {PHT_INDEX_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ
    } state_e;

    typedef struct packed {
        logic [PHT_INDEX_WIDTH-1:0] index;
        logic                       taken;
    } upd_t;

    state_e                     state_q, state_d;
    logic [PHT_INDEX_WIDTH-1:0] sweep_ptr_q, sweep_ptr_d;
    logic [QPTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [QPTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [QCNT_W-1:0]          count_q, count_d;
    upd_t                       fifo_q [QUEUE_DEPTH];

    upd_t head;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic issue;

    assign head  = fifo_q[rd_ptr_q];
    assign full  = (count_q == QCNT_W'(QUEUE_DEPTH));
    assign empty = (count_q == '0);

    // Saturating 2-bit counter step, kept to 2-bit arithmetic.
    function automatic logic [1:0] next_counter(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else       return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Queue handshake and RMW issue; a flush cycle blocks both push and issue.
    always_comb begin
        upd_ready = !full && (state_q != ST_INIT);
        push      = upd_valid && upd_ready && !flush_req;
        pop       = (state_q == ST_READ) && !flush_req;
        issue     = (state_q == ST_IDLE) && !flush_req && !empty && !fetch_rd_active;
    end

    // FIFO pointer and occupancy update; flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + QPTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + QPTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + QCNT_W'(1);
                2'b01:   count_d = count_q - QCNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state logic: sweep, wait for a queued update, then one read cycle.
    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        unique case (state_q)
            ST_INIT: begin
                if (flush_req) begin
                    sweep_ptr_d = '0;
                end else if (sweep_ptr_q == LAST_INDEX) begin
                    sweep_ptr_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    sweep_ptr_d = sweep_ptr_q + PHT_INDEX_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (flush_req)  state_d = ST_INIT;
                else if (issue) state_d = ST_READ;
            end
            ST_READ: begin
                state_d = flush_req ? ST_INIT : ST_IDLE;
            end
            default: begin
                state_d     = ST_INIT;
                sweep_ptr_d = '0;
            end
        endcase
    end

    // PHT port drive: sweep writes, read issue, and the write-back of an update.
    // NOTE: the port strobes are gated with rstN so they drop the moment reset asserts,
    // yet the very first cycle after release already writes index 0.
    always_comb begin
        init_busy    = (state_q == ST_INIT);
        pht_rd_en    = 1'b0;
        pht_rd_index = '0;
        pht_wr_en    = 1'b0;
        pht_wr_index = '0;
        pht_wr_data  = '0;
        if (rstN) begin
            unique case (state_q)
                ST_INIT: begin
                    pht_wr_en    = 1'b1;
                    pht_wr_index = sweep_ptr_q;
                    pht_wr_data  = INIT_COUNTER;
                end
                ST_IDLE: begin
                    if (issue) begin
                        pht_rd_en    = 1'b1;
                        pht_rd_index = head.index;
                    end
                end
                ST_READ: begin
                    // A flush abandons the in-flight update without writing it.
                    if (!flush_req) begin
                        pht_wr_en    = 1'b1;
                        pht_wr_index = head.index;
                        pht_wr_data  = next_counter(pht_rd_data, head.taken);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_INIT;
            sweep_ptr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Queue storage, written on push.
    // NOTE: the storage array is deliberately not reset; count_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{index: upd_index, taken: upd_taken};
    end

endmodule

// File: tb/tb_pht_update_ctrl.sv
// tb_pht_update_ctrl: directed bench for pht_update_ctrl with a 16-entry
// table and a 4-deep queue. A behavioural PHT RAM answers reads one cycle
// later, and a negedge monitor logs every write. Expected counters are
// hand-computed constants.
module tb_pht_update_ctrl;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic          upd_valid;
    logic          upd_ready;
    logic [IW-1:0] upd_index;
    logic          upd_taken;
    logic          flush_req;
    logic          fetch_rd_active;
    logic          pht_rd_en;
    logic [IW-1:0] pht_rd_index;
    logic [1:0]    pht_rd_data;
    logic          pht_wr_en;
    logic [IW-1:0] pht_wr_index;
    logic [1:0]    pht_wr_data;
    logic          init_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cyc;
        logic [IW-1:0] idx;
        logic [1:0]    data;
    } wr_t;

    wr_t        wlog [$];
    int         rd_cnt = 0;
    int         cycle_cnt = 0;
    logic [1:0] pht [16];

    pht_update_ctrl #(
        .PHT_INDEX_WIDTH(IW),
        .QUEUE_DEPTH    (4),
        .INIT_COUNTER   (2'b01)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_index      (upd_index),
        .upd_taken      (upd_taken),
        .flush_req      (flush_req),
        .fetch_rd_active(fetch_rd_active),
        .pht_rd_en      (pht_rd_en),
        .pht_rd_index   (pht_rd_index),
        .pht_rd_data    (pht_rd_data),
        .pht_wr_en      (pht_wr_en),
        .pht_wr_index   (pht_wr_index),
        .pht_wr_data    (pht_wr_data),
        .init_busy      (init_busy)
    );

    always #5 clk = ~clk;

    // PHT RAM model: read data arrives one cycle after the request.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (pht_wr_en) pht[pht_wr_index] <= pht_wr_data;
        if (pht_rd_en) pht_rd_data <= pht[pht_rd_index];
    end

    // Write/read monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (pht_wr_en) wlog.push_back('{cycle_cnt, pht_wr_index, pht_wr_data});
        if (pht_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int k = 0; k < budget && wlog.size() < n; k++) cyc();
        check("write_count", wlog.size(), n);
    endtask

    task automatic push(input logic [IW-1:0] idx, input logic tk);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = tk;
        #1;
        for (int n = 0; n < 64 && !upd_ready; n++) begin
            @(posedge clk);
            #2;
        end
        check("push_ready", upd_ready, 1'b1);
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic check_sweep(input int base);
        wait_writes(base + 16, 60);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wlog.size()) begin
                check($sformatf("sweep_idx%0d", i), wlog[base+i].idx, i);
                check($sformatf("sweep_data%0d", i), wlog[base+i].data, 2'b01);
                if (i > 0) check($sformatf("sweep_cyc%0d", i), wlog[base+i].cyc - wlog[base].cyc, i);
            end
        end
        #1;
        check("sweep_done_busy", init_busy, 1'b0);
        check("sweep_done_ready", upd_ready, 1'b1);
    endtask

    task automatic check_writes(input string tag, input int base, input logic [IW-1:0] idx[],
                                input logic [1:0] data[]);
        for (int i = 0; i < idx.size(); i++) begin
            if (base + i < wlog.size()) begin
                check($sformatf("%s_idx%0d", tag, i), wlog[base+i].idx, idx[i]);
                check($sformatf("%s_data%0d", tag, i), wlog[base+i].data, data[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase;
        int rbase;
        int c0;

        rstN            = 1'b0;
        upd_valid       = 1'b0;
        upd_index       = '0;
        upd_taken       = 1'b0;
        flush_req       = 1'b0;
        fetch_rd_active = 1'b0;

        // Reset values.
        cyc();
        cyc();
        #1;
        check("rst_busy", init_busy, 1'b1);
        check("rst_ready", upd_ready, 1'b0);
        check("rst_wr_en", pht_wr_en, 1'b0);
        check("rst_rd_en", pht_rd_en, 1'b0);
        check("rst_wr_data", pht_wr_data, 2'b00);

        // Release: 16 consecutive sweep writes starting at index 0.
        cyc();
        rstN = 1'b1;
        #1;
        check("first_wr_en", pht_wr_en, 1'b1);
        check("first_wr_idx", pht_wr_index, 0);
        check_sweep(0);

        // Saturate up, then down, on index 3.
        wbase = wlog.size();
        cyc();
        push(3, 1); push(3, 1); push(3, 1);
        push(3, 0); push(3, 0); push(3, 0); push(3, 0);
        wait_writes(wbase + 7, 100);
        check_writes("sat", wbase, '{3, 3, 3, 3, 3, 3, 3}, '{2, 3, 3, 2, 1, 0, 0});

        // Fill the queue while fetch owns the read port.
        cyc();
        wbase = wlog.size();
        rbase = rd_cnt;
        fetch_rd_active = 1'b1;
        push(1, 1); push(2, 0); push(1, 1); push(6, 0);
        #1;
        check("full_ready", upd_ready, 1'b0);
        upd_valid = 1'b1; upd_index = 13; upd_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            check("full_block", upd_ready, 1'b0);
        end
        cyc();
        upd_valid = 1'b0;
        check("blocked_rd", rd_cnt - rbase, 0);
        check("blocked_wr", wlog.size() - wbase, 0);
        fetch_rd_active = 1'b0;
        c0 = cycle_cnt;
        repeat (8) cyc();
        check("drain_count", wlog.size() - wbase, 4);
        check_writes("drain", wbase, '{1, 2, 1, 6}, '{2, 0, 3, 0});
        for (int i = 0; i < 4; i++)
            if (wbase + i < wlog.size())
                check($sformatf("drain_cyc%0d", i), wlog[wbase+i].cyc - c0, 1 + 2 * i);
        #1;
        check("drain_ready", upd_ready, 1'b1);
        repeat (4) cyc();
        check("no_extra_push", wlog.size() - wbase, 4);

        // Push and pop in the same cycle at count 2.
        wbase = wlog.size();
        fetch_rd_active = 1'b1;
        push(7, 1); push(8, 1);
        fetch_rd_active = 1'b0;
        #1;
        check("pp_rd_en", pht_rd_en, 1'b1);
        check("pp_rd_idx", pht_rd_index, 7);
        cyc();
        upd_valid = 1'b1; upd_index = 9; upd_taken = 1'b0;
        fetch_rd_active = 1'b1;
        #1;
        check("pp_wr_en", pht_wr_en, 1'b1);
        check("pp_wr_data", pht_wr_data, 2'b10);
        check("pp_ready", upd_ready, 1'b1);
        cyc();
        upd_index = 10; upd_taken = 1'b1;
        #1;
        check("pp_fetch_block", pht_rd_en, 1'b0);
        check("pp_ready3", upd_ready, 1'b1);
        cyc();
        upd_index = 11; upd_taken = 1'b0;
        #1;
        check("pp_ready4", upd_ready, 1'b1);
        cyc();
        upd_valid = 1'b0;
        #1;
        check("pp_full", upd_ready, 1'b0);
        fetch_rd_active = 1'b0;
        wait_writes(wbase + 5, 60);
        check_writes("pp", wbase, '{7, 8, 9, 10, 11}, '{2, 2, 0, 2, 0});

        // Ten streamed updates wrap the queue pointers.
        cyc();
        wbase = wlog.size();
        push(12, 1); push(13, 1); push(12, 1); push(13, 0); push(12, 1);
        push(14, 0); push(14, 0); push(15, 1); push(15, 1); push(15, 1);
        wait_writes(wbase + 10, 100);
        check_writes("wrap", wbase, '{12, 13, 12, 13, 12, 14, 14, 15, 15, 15},
                     '{2, 2, 3, 1, 3, 0, 0, 2, 3, 3});

        // Flush in the READ cycle of index 5.
        cyc();
        wbase = wlog.size();
        fetch_rd_active = 1'b1;
        push(5, 1); push(6, 1); push(7, 1);
        fetch_rd_active = 1'b0;
        #1;
        check("fl_rd_idx", pht_rd_index, 5);
        cyc();
        flush_req = 1'b1;
        upd_valid = 1'b1; upd_index = 9; upd_taken = 1'b1;
        #1;
        check("fl_no_wr", pht_wr_en, 1'b0);
        cyc();
        flush_req = 1'b0;
        upd_valid = 1'b0;
        #1;
        check("fl_busy", init_busy, 1'b1);
        check("fl_wr_idx", pht_wr_index, 0);
        check_sweep(wbase);
        rbase = rd_cnt;
        repeat (10) cyc();
        check("fl_dropped_wr", wlog.size() - wbase, 16);
        check("fl_dropped_rd", rd_cnt - rbase, 0);

        // Reset asserted mid-sweep at pointer 7.
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        repeat (7) cyc();
        #1;
        check("mid_wr_idx", pht_wr_index, 7);
        rstN = 1'b0;
        #1;
        check("mid_rst_wr_en", pht_wr_en, 1'b0);
        check("mid_rst_idx", pht_wr_index, 0);
        check("mid_rst_busy", init_busy, 1'b1);
        check("mid_rst_ready", upd_ready, 1'b0);
        cyc();
        cyc();
        wbase = wlog.size();
        rstN = 1'b1;
        check_sweep(wbase);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
